// File: rtl/updown_counter_param_if.sv
// Control/status bundle for the parametrised up/down counter.
// The master drives the count controls; the slave (the counter) returns the
// count, terminal-count and wrap/clamp indication.
interface updown_counter_param_if #(
   parameter int unsigned WIDTH = 4
);
   logic             en;
   logic             sel;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] out;
   logic             tc;
   logic             wrap;

   modport master (
      output en, sel, clr, load, load_val,
      input  out, tc, wrap
   );

   modport slave (
      input  en, sel, clr, load, load_val,
      output out, tc, wrap
   );
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised synchronous up/down counter.
// Count range is 0..MAX_VAL; stepping past either limit either wraps to the
// opposite limit or clamps at the limit (SATURATE), and in both cases a
// registered one-cycle wrap pulse is raised. Priority: clr > load > en > hold.
// tc is combinational so chained counters can enable on the same cycle.
module updown_counter_param #(
   parameter int unsigned      WIDTH     = 4,
   parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
   parameter bit               SATURATE  = 1'b0,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input logic                   clk,
   input logic                   rst_n,
   updown_counter_param_if.slave bus
);

   localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_d;
   logic             wrap_q;
   logic             wrap_d;
   logic             at_max_s;
   logic             at_zero_s;

   assign at_max_s  = (out_q == MAX_VAL);
   assign at_zero_s = (out_q == ZERO_C);

   // Next-count and wrap-pulse selection in priority order clr > load > en > hold.
   always_comb begin
      out_d  = out_q;
      wrap_d = 1'b0;
      if (bus.clr) begin
         out_d = RESET_VAL;
      end else if (bus.load) begin
         // Oversized load values clamp to the top of range rather than truncating.
         out_d = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
      end else if (bus.en) begin
         if (bus.sel) begin
            if (at_max_s) begin
               out_d  = SATURATE ? MAX_VAL : ZERO_C;
               wrap_d = 1'b1;
            end else begin
               out_d = out_q + ONE_C;
            end
         end else begin
            if (at_zero_s) begin
               out_d  = SATURATE ? ZERO_C : MAX_VAL;
               wrap_d = 1'b1;
            end else begin
               out_d = out_q - ONE_C;
            end
         end
      end else begin
         out_d = out_q;
      end
   end

   // Count and wrap registers; asynchronous reset returns to RESET_VAL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= RESET_VAL;
         wrap_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.out  = out_q;
   assign bus.wrap = wrap_q;
   assign bus.tc   = bus.en & (bus.sel ? at_max_s : at_zero_s);

endmodule
